// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - shared constants and types for the multiply/divide unit
//
// Purpose: operand width, op encodings and FSM state encodings shared by the
// multiply/divide unit, the decoder and the hazard unit.
// Ports: none (package).

package mul_div_unit_pkg;

  localparam int MDU_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_RUN  = 2'b01,
    MDU_FIX  = 2'b10
  } mdu_state_e;

  // Bit 1 of the op selects divide, bit 0 selects the unsigned flavour.
  function automatic logic mdu_is_div(input logic [1:0] o);
    return o[1];
  endfunction

  function automatic logic mdu_is_signed(input logic [1:0] o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide unit owning the HI/LO registers
//
// Purpose: 32-iteration shift-add multiply and restoring divide, signed or
// unsigned, with architectural HI/LO registers also writable by MTHI/MTLO.
// Ports:
//   clk    in   clock, all state updates on the rising edge
//   rst    in   asynchronous active-high reset
//   start  in   request an operation, sampled only in IDLE
//   op     in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A, B   in   operands, captured when start is accepted
//   hi_we  in   MTHI write enable (IDLE only)
//   lo_we  in   MTLO write enable (IDLE only)
//   wdata  in   MTHI/MTLO write data
//   busy   out  state is not IDLE
//   done   out  one-cycle pulse, HI/LO hold the new result in the same cycle
//   hi, lo out  HI and LO registers

module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = MDU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  hi_we,
  input  logic                  lo_we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam int WW = 2 * W + 1;

  mdu_state_e      state_q, state_d;
  mdu_op_e         op_q, op_d;
  // Multiply: {0, product[2W-1:0]}, multiplier consumed from the low end.
  // Divide:   {remainder[W:0], quotient[W-1:0]}, dividend shifted out of the low half.
  logic [WW-1:0]   work_q, work_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [W-1:0]    opnd_q, opnd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sign_q, sign_d;       // product / quotient must be negated
  logic            rem_neg_q, rem_neg_d; // remainder takes the dividend's sign
  logic            dbz_q, dbz_d;         // divide by zero
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            done_q, done_d;

  // Operand capture: magnitudes for signed ops, raw values otherwise.
  logic            in_div;
  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;

  assign in_div = mdu_is_div(op);
  assign a_neg  = mdu_is_signed(op) & A[W-1];
  assign b_neg  = mdu_is_signed(op) & B[W-1];
  assign a_mag  = a_neg ? -A : A;
  assign b_mag  = b_neg ? -B : B;

  // Shift-add multiply step: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole register right.
  logic [W:0]      mul_sum;
  logic [WW-1:0]   mul_step;

  assign mul_sum  = {1'b0, work_q[2*W-1:W]} + (work_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step = {1'b0, mul_sum, work_q[W-1:1]};

  // Restoring divide step: shift the next dividend bit into the remainder and
  // try to subtract the divisor. The extra top bit of the trial difference is
  // the borrow, which selects restore (quotient bit 0) or keep (bit 1).
  logic [W+1:0]    div_shift, div_trial;
  logic [WW-1:0]   div_step;

  assign div_shift = {work_q[2*W:W], work_q[W-1]};
  assign div_trial = div_shift - {2'b00, opnd_q};
  assign div_step  = div_trial[W+1] ? {div_shift[W:0], work_q[W-2:0], 1'b0}
                                    : {div_trial[W:0], work_q[W-2:0], 1'b1};

  // Sign correction applied in FIX.
  logic [2*W-1:0]  prod_mag, prod_fix;
  logic [W-1:0]    quot_mag, quot_fix, rem_mag, rem_fix;

  assign prod_mag = work_q[2*W-1:0];
  assign prod_fix = sign_q ? -prod_mag : prod_mag;
  assign quot_mag = work_q[W-1:0];
  assign rem_mag  = work_q[2*W-1:W];
  // Divide by zero leaves the remainder equal to |A|; re-applying A's sign
  // makes HI equal the raw dividend, and LO is forced to all ones.
  assign quot_fix = dbz_q ? '1 : (sign_q ? -quot_mag : quot_mag);
  assign rem_fix  = rem_neg_q ? -rem_mag : rem_mag;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    work_d    = work_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    rem_neg_d = rem_neg_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      MDU_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d   = MDU_RUN;
          op_d      = mdu_op_e'(op);
          cnt_d     = '0;
          sign_d    = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          dbz_d     = in_div & (B == '0);
          if (in_div) begin
            work_d = {{(W+1){1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            work_d = {{(W+1){1'b0}}, b_mag};
            opnd_d = a_mag;
          end
        end
      end

      MDU_RUN: begin
        work_d = mdu_is_div(op_q) ? div_step : mul_step;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = MDU_FIX;
      end

      MDU_FIX: begin
        if (mdu_is_div(op_q)) begin
          lo_d = quot_fix;
          hi_d = rem_fix;
        end else begin
          lo_d = prod_fix[W-1:0];
          hi_d = prod_fix[2*W-1:W];
        end
        done_d  = 1'b1;
        state_d = MDU_IDLE;
      end

      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= MDU_IDLE;
      op_q      <= MDU_MULT;
      work_q    <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      work_q    <= work_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      rem_neg_q <= rem_neg_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != MDU_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit

module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B, wdata;
  logic        hi_we, lo_we;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_pass  = 0;
  int n_total = 0;

  mul_div_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'd0: r = sa * sb;
      2'd1: r = ua * ub;
      2'd2: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          r  = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Assumes the caller is at a negedge: drive start, let E0 sample it, then scramble inputs.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom);
    A  = $urandom;
    B  = $urandom;
  endtask

  // Cycle number (start cycle = 0) of the negedge where done is first seen, -1 on timeout.
  task automatic wait_done(input int first, output int lat);
    lat = -1;
    for (int c = first; c <= 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    launch(o, a, b);
    wait_done(1, lat);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else n_pass++;
    n_total++; if (hi !== 32'd0) $display("FAIL reset_hi got %h want 0", hi); else n_pass++;
    n_total++; if (lo !== 32'd0) $display("FAIL reset_lo got %h want 0", lo); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL post_reset_busy got %0b want 0", busy); else n_pass++;
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2};
    logic [31:0] t_a  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7,
                              32'h0000_1234, 32'h8000_0000, 32'hFFFF_FFF9, 32'd7};
    logic [31:0] t_b  [8] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE};
    logic [31:0] t_hi [8] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'd1,
                              32'h0000_1234, 32'd0, 32'hFFFF_FFF9, 32'd1};
    logic [31:0] t_lo [8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd3,
                              32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], lat);
      n_total++; if (lat !== 34) $display("FAIL directed%0d_latency got %0d want 34", i, lat); else n_pass++;
      n_total++; if (hi !== t_hi[i]) $display("FAIL directed%0d_hi got %h want %h", i, hi, t_hi[i]); else n_pass++;
      n_total++; if (lo !== t_lo[i]) $display("FAIL directed%0d_lo got %h want %h", i, lo, t_lo[i]); else n_pass++;
      @(negedge clk);
      n_total++; if (done !== 1'b0) $display("FAIL directed%0d_done_width got %0b want 0", i, done); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] exp;
    int lat;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom);
      a = pick_operand();
      b = pick_operand();
      exp = model(o, a, b);
      run_op(o, a, b, lat);
      n_total++; if (lat !== 34) $display("FAIL random%0d_latency got %0d want 34", i, lat); else n_pass++;
      n_total++;
      if ({hi, lo} !== exp)
        $display("FAIL random%0d op=%0d a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h",
                 i, o, a, b, hi, lo, exp[63:32], exp[31:0]);
      else n_pass++;
    end
  endtask

  task automatic test_busy_ignore();
    logic [63:0] exp;
    logic [31:0] h0, l0;
    logic        changed, idle_seen;
    int lat;
    exp = model(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk);
    h0 = hi; l0 = lo;
    changed = 1'b0; idle_seen = 1'b0;
    launch(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      if (hi !== h0 || lo !== l0) changed = 1'b1;
      if (busy !== 1'b1) idle_seen = 1'b1;
      start = (c == 5);
      if (c == 5) begin op = 2'd3; A = 32'd100; B = 32'd7; end
      hi_we = (c == 10);
      if (c == 10) wdata = 32'h0000_DEAD;
    end
    start = 1'b0; hi_we = 1'b0;
    n_total++; if (lat !== 34) $display("FAIL ignore_latency got %0d want 34", lat); else n_pass++;
    n_total++; if (changed !== 1'b0) $display("FAIL ignore_hilo_stable_during_run got %0b want 0", changed); else n_pass++;
    n_total++; if (idle_seen !== 1'b0) $display("FAIL ignore_busy_during_run got %0b want 0", idle_seen); else n_pass++;
    n_total++; if (hi !== exp[63:32]) $display("FAIL ignore_hi got %h want %h", hi, exp[63:32]); else n_pass++;
    n_total++; if (lo !== exp[31:0]) $display("FAIL ignore_lo got %h want %h", lo, exp[31:0]); else n_pass++;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL ignore_no_second_op got busy=%0b want 0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] e1, e2;
    int lat;
    e1 = model(2'd1, 32'hDEAD_BEEF, 32'h0000_1001);
    e2 = model(2'd2, 32'hFFFF_F000, 32'h0000_0007);
    run_op(2'd1, 32'hDEAD_BEEF, 32'h0000_1001, lat);
    n_total++; if ({hi, lo} !== e1) $display("FAIL b2b_first got %h%h want %h", hi, lo, e1); else n_pass++;
    // still in the done cycle: start here must be accepted
    launch(2'd2, 32'hFFFF_F000, 32'h0000_0007);
    wait_done(1, lat);
    n_total++; if (lat !== 34) $display("FAIL b2b_second_latency got %0d want 34", lat); else n_pass++;
    n_total++; if ({hi, lo} !== e2) $display("FAIL b2b_second got %h%h want %h", hi, lo, e2); else n_pass++;
  endtask

  task automatic test_mt_writes();
    logic [31:0] h0;
    int lat;
    @(negedge clk);
    h0 = hi;
    lo_we = 1'b1; wdata = 32'h0000_ABCD;
    @(posedge clk); #1; lo_we = 1'b0;
    @(negedge clk);
    n_total++; if (lo !== 32'h0000_ABCD) $display("FAIL mtlo got %h want 0000abcd", lo); else n_pass++;
    n_total++; if (hi !== h0) $display("FAIL mtlo_hi_untouched got %h want %h", hi, h0); else n_pass++;
    hi_we = 1'b1; wdata = 32'h5555_AAAA;
    @(posedge clk); #1; hi_we = 1'b0;
    @(negedge clk);
    n_total++; if (hi !== 32'h5555_AAAA) $display("FAIL mthi got %h want 5555aaaa", hi); else n_pass++;
    n_total++; if (lo !== 32'h0000_ABCD) $display("FAIL mthi_lo_untouched got %h want 0000abcd", lo); else n_pass++;
    // MTHI alongside an accepted start: written at once, then overwritten by FIX
    hi_we = 1'b1; wdata = 32'h0000_CAFE;
    launch(2'd1, 32'd3, 32'd5);
    hi_we = 1'b0;
    @(negedge clk);
    n_total++; if (hi !== 32'h0000_CAFE) $display("FAIL mthi_with_start got %h want 0000cafe", hi); else n_pass++;
    wait_done(2, lat);
    n_total++; if (lat !== 34) $display("FAIL mthi_with_start_latency got %0d want 34", lat); else n_pass++;
    n_total++; if ({hi, lo} !== 64'd15) $display("FAIL fix_wins got %h%h want 15", hi, lo); else n_pass++;
  endtask

  task automatic test_rst_mid();
    logic [63:0] exp;
    logic        done_seen;
    int lat;
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1111_1111;
    @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
    @(negedge clk);
    launch(2'd0, 32'hFFFF_FFFD, 32'd7);
    for (int c = 1; c <= 12; c++) @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %0b want 0", busy); else n_pass++;
    n_total++; if (hi !== 32'd0) $display("FAIL rst_mid_hi got %h want 0", hi); else n_pass++;
    n_total++; if (lo !== 32'd0) $display("FAIL rst_mid_lo got %h want 0", lo); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rst_mid_done got %0b want 0", done); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
    end
    n_total++; if (done_seen !== 1'b0) $display("FAIL rst_mid_no_done got %0b want 0", done_seen); else n_pass++;
    exp = model(2'd2, 32'hFFFF_FF9C, 32'd7);
    run_op(2'd2, 32'hFFFF_FF9C, 32'd7, lat);
    n_total++; if (lat !== 34) $display("FAIL rst_after_latency got %0d want 34", lat); else n_pass++;
    n_total++; if ({hi, lo} !== exp) $display("FAIL rst_after_result got %h%h want %h", hi, lo, exp); else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'd0; A = '0; B = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_mt_writes();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
